// File: rtl/misalign_seq.sv
// Memory-stage sequencer that splits word-crossing loads/stores into two aligned accesses.
// Splitting is enabled by defining MISALIGN_SPLIT_EN; otherwise crossing accesses are flagged.
module misalign_seq #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    input  logic [31:0]       i_wdata,
    input  logic              i_flush,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_bmask,
    output logic              o_mem_we,
    input  logic [31:0]       i_mem_rdata,
    output logic [31:0]       o_rdata,
    output logic              o_done,
    output logic              o_stall_req,
    output logic              o_misaligned
);

    function automatic logic [31:0] f_extend(input logic [31:0] d, input logic [1:0] size,
                                             input logic uns);
        logic [31:0] r;
        case (size)
            2'd0:    r = uns ? {24'h0, d[7:0]} : {{24{d[7]}}, d[7:0]};
            2'd1:    r = uns ? {16'h0, d[15:0]} : {{16{d[15]}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    logic [1:0]        w_off;
    logic [2:0]        w_nbytes;
    logic [3:0]        w_base_mask;
    logic [2:0]        w_sum;
    logic              w_cross;
    logic [4:0]        w_sh;
    logic [63:0]       w_wdata64;
    logic [7:0]        w_mask8;
    logic [31:0]       w_rd_idle;
    logic [ADDR_W-1:0] w_word_addr;

    assign w_off = i_addr[1:0];

    always_comb begin
        w_nbytes    = 3'd4;
        w_base_mask = 4'b1111;
        case (i_size)
            2'd0: begin
                w_nbytes    = 3'd1;
                w_base_mask = 4'b0001;
            end
            2'd1: begin
                w_nbytes    = 3'd2;
                w_base_mask = 4'b0011;
            end
            default: begin
                w_nbytes    = 3'd4;
                w_base_mask = 4'b1111;
            end
        endcase
    end

    assign w_sum       = {1'b0, w_off} + w_nbytes;
    assign w_cross     = i_valid & (w_sum > 3'd4);
    assign w_sh        = {w_off, 3'b000};
    // Upper halves of these 64-bit shifts are the high-word lanes of a split access.
    assign w_wdata64   = {32'h0, i_wdata} << w_sh;
    assign w_mask8     = {4'h0, w_base_mask} << w_off;
    assign w_rd_idle   = i_mem_rdata >> w_sh;
    assign w_word_addr = {i_addr[ADDR_W-1:2], 2'b00};

`ifdef MISALIGN_SPLIT_EN
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HI   = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [31:0]       r_lo_buf;
    logic [31:0]       w_lo_nxt;
    logic [63:0]       w_rd64;
    logic [ADDR_W-1:0] w_hi_addr;

    assign w_rd64    = {i_mem_rdata, r_lo_buf} >> w_sh;
    assign w_hi_addr = w_word_addr + ADDR_W'(3'd4);

    always_comb begin
        o_mem_addr   = w_word_addr;
        o_mem_wdata  = w_wdata64[31:0];
        o_mem_bmask  = w_mask8[3:0];
        o_mem_we     = i_valid & i_we;
        o_rdata      = f_extend(w_rd_idle, i_size, i_unsigned);
        o_done       = i_valid;
        o_stall_req  = 1'b0;
        o_misaligned = 1'b0;
        w_state_nxt  = IDLE;
        w_lo_nxt     = r_lo_buf;
        if (r_state == IDLE) begin
            if (w_cross) begin
                o_done      = 1'b0;
                o_stall_req = 1'b1;
                w_lo_nxt    = i_mem_rdata;
                w_state_nxt = HI;
            end
        end else begin
            o_mem_addr  = w_hi_addr;
            o_mem_wdata = w_wdata64[63:32];
            o_mem_bmask = w_mask8[7:4];
            o_mem_we    = i_we & ~i_flush;
            o_rdata     = f_extend(w_rd64[31:0], i_size, i_unsigned);
            o_done      = ~i_flush;
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_lo_buf <= 32'h0;
        end else begin
            r_state  <= w_state_nxt;
            r_lo_buf <= w_lo_nxt;
        end
    end
`else
    logic w_unused_split;
    assign w_unused_split = ^{i_clk, i_reset, i_flush, w_wdata64[63:32], w_mask8[7:4]};

    always_comb begin
        o_mem_addr   = w_word_addr;
        o_mem_wdata  = w_wdata64[31:0];
        o_mem_bmask  = w_mask8[3:0];
        o_mem_we     = i_valid & i_we;
        o_rdata      = f_extend(w_rd_idle, i_size, i_unsigned);
        o_done       = i_valid;
        o_stall_req  = 1'b0;
        o_misaligned = 1'b0;
        if (w_cross) begin
            o_mem_we     = 1'b0;
            o_rdata      = 32'h0;
            o_misaligned = 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_misalign_seq.sv
// Directed self-checking bench for misalign_seq with a byte-maskable word memory model.
// Split-access scenarios run when MISALIGN_SPLIT_EN is defined, the misaligned flag otherwise.
module tb_misalign_seq;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic        flush;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_bmask;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic [31:0] rdata;
    logic        done;
    logic        stall_req;
    logic        misaligned;

    logic        preload;
    logic [31:0] mem [0:127];
    int          checks;
    int          errors;

    misalign_seq #(.ADDR_W(32)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_valid      (valid),
        .i_we         (we),
        .i_addr       (addr),
        .i_size       (size),
        .i_unsigned   (uns),
        .i_wdata      (wdata),
        .i_flush      (flush),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_mem_bmask  (mem_bmask),
        .o_mem_we     (mem_we),
        .i_mem_rdata  (mem_rdata),
        .o_rdata      (rdata),
        .o_done       (done),
        .o_stall_req  (stall_req),
        .o_misaligned (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[8:2]];

    // 0x100 -> index 64, 0x104 -> 65, 0xFFFFFFFC -> 127, 0x0 -> 0
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
            mem[64]  <= 32'h44332211;
            mem[65]  <= 32'h88776655;
            mem[127] <= 32'hDDCCBBAA;
            mem[0]   <= 32'h11223344;
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_bmask[b]) mem[mem_addr[8:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic drive(input logic v, input logic w, input logic [31:0] a, input logic [1:0] s,
                         input logic u, input logic [31:0] d, input logic f);
        valid = v; we = w; addr = a; size = s; uns = u; wdata = d; flush = f;
    endtask

    task automatic test_reset;
        rst = 1'b1; preload = 1'b1;
        drive(1'b1, 1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        @(negedge clk); #2;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", stall_req); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rst_done got %b want 1", done); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL rst_addr got %h want 00000100", mem_addr); end
        checks++; if (rdata !== 32'h44332211) begin errors++; $display("FAIL rst_rdata got %h want 44332211", rdata); end
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL rst_mis got %b want 0", misaligned); end
        @(negedge clk);
        rst = 1'b0; preload = 1'b0;
    endtask

    task automatic test_nocross;
        @(negedge clk); drive(1'b1, 1'b0, 32'h102, 2'd1, 1'b0, 32'h0, 1'b0); #2;
        checks++; if (rdata !== 32'h00004433) begin errors++; $display("FAIL lh_rdata got %h want 00004433", rdata); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL lh_stall got %b want 0", stall_req); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL lh_done got %b want 1", done); end
        @(negedge clk); drive(1'b1, 1'b0, 32'h107, 2'd0, 1'b0, 32'h0, 1'b0); #2;
        checks++; if (rdata !== 32'hFFFFFF88) begin errors++; $display("FAIL lb_rdata got %h want ffffff88", rdata); end
        checks++; if (mem_addr !== 32'h104) begin errors++; $display("FAIL lb_addr got %h want 00000104", mem_addr); end
        @(negedge clk); drive(1'b1, 1'b0, 32'h107, 2'd0, 1'b1, 32'h0, 1'b0); #2;
        checks++; if (rdata !== 32'h00000088) begin errors++; $display("FAIL lbu_rdata got %h want 00000088", rdata); end
        // Flush while idle must not disturb a normal access
        @(negedge clk); drive(1'b1, 1'b0, 32'h101, 2'd0, 1'b1, 32'h0, 1'b1); #2;
        checks++; if (rdata !== 32'h00000022) begin errors++; $display("FAIL lbu_flush_rdata got %h want 00000022", rdata); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL lbu_flush_done got %b want 1", done); end
        @(negedge clk); drive(1'b1, 1'b1, 32'h105, 2'd0, 1'b0, 32'h000000EE, 1'b0); #2;
        checks++; if (mem_bmask !== 4'b0010) begin errors++; $display("FAIL sb_mask got %b want 0010", mem_bmask); end
        checks++; if (mem_wdata !== 32'h0000EE00) begin errors++; $display("FAIL sb_wdata got %h want 0000ee00", mem_wdata); end
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL sb_we got %b want 1", mem_we); end
        // Undo the byte store so later scenarios see the preloaded word
        @(negedge clk); drive(1'b1, 1'b1, 32'h105, 2'd0, 1'b0, 32'h00000066, 1'b0);
        @(negedge clk); drive(1'b0, 1'b0, 32'h104, 2'd2, 1'b0, 32'h0, 1'b0); #2;
        checks++; if (mem[65] !== 32'h88776655) begin errors++; $display("FAIL sb_restore got %h want 88776655", mem[65]); end
    endtask

`ifdef MISALIGN_SPLIT_EN
    task automatic test_split_load;
        @(negedge clk); drive(1'b1, 1'b0, 32'h101, 2'd2, 1'b0, 32'h0, 1'b0); #2;
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL lw1_addr got %h want 00000100", mem_addr); end
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL lw1_stall got %b want 1", stall_req); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL lw1_done got %b want 0", done); end
        @(negedge clk); #2;
        checks++; if (mem_addr !== 32'h104) begin errors++; $display("FAIL lw2_addr got %h want 00000104", mem_addr); end
        checks++; if (rdata !== 32'h55443322) begin errors++; $display("FAIL lw2_rdata got %h want 55443322", rdata); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL lw2_done got %b want 1", done); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL lw2_stall got %b want 0", stall_req); end
        @(negedge clk); drive(1'b0, 1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_reset_mid;
        @(negedge clk); drive(1'b1, 1'b0, 32'h103, 2'd2, 1'b0, 32'h0, 1'b0); #2;
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL rm_lo_stall got %b want 1", stall_req); end
        @(negedge clk);
        rst = 1'b1; valid = 1'b0; #2;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL rm_stall got %b want 0", stall_req); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL rm_addr got %h want 00000100", mem_addr); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rm_done got %b want 0", done); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rm_we got %b want 0", mem_we); end
        @(negedge clk); rst = 1'b0;
        drive(1'b1, 1'b0, 32'h104, 2'd2, 1'b0, 32'h0, 1'b0); #2;
        checks++; if (rdata !== 32'h88776655) begin errors++; $display("FAIL rm_lw_rdata got %h want 88776655", rdata); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rm_lw_done got %b want 1", done); end
    endtask

    task automatic test_split_store;
        @(negedge clk); drive(1'b1, 1'b1, 32'h102, 2'd2, 1'b0, 32'hAABBCCDD, 1'b0); #2;
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL sw1_addr got %h want 00000100", mem_addr); end
        checks++; if (mem_bmask !== 4'b1100) begin errors++; $display("FAIL sw1_mask got %b want 1100", mem_bmask); end
        checks++; if (mem_wdata !== 32'hCCDD0000) begin errors++; $display("FAIL sw1_wdata got %h want ccdd0000", mem_wdata); end
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL sw1_stall got %b want 1", stall_req); end
        @(negedge clk); #2;
        checks++; if (mem_addr !== 32'h104) begin errors++; $display("FAIL sw2_addr got %h want 00000104", mem_addr); end
        checks++; if (mem_bmask !== 4'b0011) begin errors++; $display("FAIL sw2_mask got %b want 0011", mem_bmask); end
        checks++; if (mem_wdata !== 32'h0000AABB) begin errors++; $display("FAIL sw2_wdata got %h want 0000aabb", mem_wdata); end
        checks++; if (mem_we !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL sw2_we_done got %b%b want 11", mem_we, done); end
        @(negedge clk); drive(1'b0, 1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 1'b0); #2;
        checks++; if (mem[64] !== 32'hCCDD2211) begin errors++; $display("FAIL sw_mem100 got %h want ccdd2211", mem[64]); end
        checks++; if (mem[65] !== 32'h8877AABB) begin errors++; $display("FAIL sw_mem104 got %h want 8877aabb", mem[65]); end
    endtask

    task automatic test_flush;
        @(negedge clk); drive(1'b1, 1'b1, 32'h103, 2'd1, 1'b0, 32'h00001234, 1'b0); #2;
        checks++; if (mem_bmask !== 4'b1000) begin errors++; $display("FAIL sh1_mask got %b want 1000", mem_bmask); end
        checks++; if (mem_wdata !== 32'h34000000) begin errors++; $display("FAIL sh1_wdata got %h want 34000000", mem_wdata); end
        @(negedge clk); flush = 1'b1; #2;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL fl_we got %b want 0", mem_we); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL fl_done got %b want 0", done); end
        checks++; if (mem_bmask !== 4'b0001) begin errors++; $display("FAIL fl_mask got %b want 0001", mem_bmask); end
        @(negedge clk); drive(1'b1, 1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 1'b0); #2;
        checks++; if (rdata !== 32'h34DD2211) begin errors++; $display("FAIL fl_lw_rdata got %h want 34dd2211", rdata); end
        checks++; if (done !== 1'b1 || stall_req !== 1'b0) begin errors++; $display("FAIL fl_lw_done_stall got %b%b want 10", done, stall_req); end
        checks++; if (mem[65] !== 32'h8877AABB) begin errors++; $display("FAIL fl_mem104 got %h want 8877aabb", mem[65]); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk); drive(1'b1, 1'b0, 32'h103, 2'd1, 1'b0, 32'h0, 1'b0); #2;
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL bb1_stall got %b want 1", stall_req); end
        @(negedge clk); #2;
        checks++; if (rdata !== 32'hFFFFBB34) begin errors++; $display("FAIL bb1_rdata got %h want ffffbb34", rdata); end
        @(negedge clk); drive(1'b1, 1'b0, 32'h102, 2'd2, 1'b0, 32'h0, 1'b0); #2;
        checks++; if (stall_req !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL bb2_lo got stall %b addr %h want 1 00000100", stall_req, mem_addr); end
        @(negedge clk); #2;
        checks++; if (rdata !== 32'hAABB34DD) begin errors++; $display("FAIL bb2_rdata got %h want aabb34dd", rdata); end
    endtask

    task automatic test_wrap;
        @(negedge clk); drive(1'b1, 1'b0, 32'hFFFFFFFE, 2'd2, 1'b0, 32'h0, 1'b0); #2;
        checks++; if (mem_addr !== 32'hFFFFFFFC) begin errors++; $display("FAIL wr1_addr got %h want fffffffc", mem_addr); end
        @(negedge clk); #2;
        checks++; if (mem_addr !== 32'h00000000) begin errors++; $display("FAIL wr2_addr got %h want 00000000", mem_addr); end
        checks++; if (rdata !== 32'h3344DDCC) begin errors++; $display("FAIL wr2_rdata got %h want 3344ddcc", rdata); end
        @(negedge clk); drive(1'b0, 1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 1'b0);
    endtask
`else
    task automatic test_misaligned;
        @(negedge clk); drive(1'b1, 1'b0, 32'h101, 2'd2, 1'b0, 32'h0, 1'b0); #2;
        checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL mis_flag got %b want 1", misaligned); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL mis_done got %b want 1", done); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL mis_stall got %b want 0", stall_req); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL mis_we got %b want 0", mem_we); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL mis_rdata got %h want 00000000", rdata); end
        @(negedge clk); drive(1'b1, 1'b1, 32'h103, 2'd1, 1'b0, 32'h00001234, 1'b0); #2;
        checks++; if (mem_we !== 1'b0 || misaligned !== 1'b1) begin errors++; $display("FAIL mis_sh got we %b mis %b want 0 1", mem_we, misaligned); end
        @(negedge clk); drive(1'b1, 1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 1'b0); #2;
        checks++; if (rdata !== 32'h44332211) begin errors++; $display("FAIL al_rdata got %h want 44332211", rdata); end
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL al_mis got %b want 0", misaligned); end
        checks++; if (mem[64] !== 32'h44332211) begin errors++; $display("FAIL mis_mem100 got %h want 44332211", mem[64]); end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
        test_reset();
`ifdef MISALIGN_SPLIT_EN
        test_split_load();
`endif
        test_nocross();
`ifdef MISALIGN_SPLIT_EN
        test_reset_mid();
        test_split_store();
        test_flush();
        test_back_to_back();
        test_wrap();
`else
        test_misaligned();
`endif
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
